mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port `memory` instance between instruction fetch (IF) and data access (DM).
//  Sits between the PC/fetch logic, the EXE/MEM pipeline register and the memory.
//  Issues at most one access per cycle and tags each read so data_out returns to its owner one cycle later.
//  Drives stall_if so that the PC holds while fetch is denied.
// PARAMETERS
//  AW           16  address width (matches `ISIZE)
//  DW           16  data width (matches `DSIZE)
//  STARVE_LIMIT 4   max consecutive cycles IF may be denied while requesting; range 1..15
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous reset, active-low
//  if_req     in   1   fetch read request
//  if_addr    in   AW  fetch address
//  if_gnt     out  1   fetch request accepted this cycle
//  if_rvalid  out  1   if_rdata valid (one cycle after if_gnt)
//  if_rdata   out  DW  fetched instruction
//  dm_req     in   1   data request
//  dm_we      in   1   1=write, 0=read
//  dm_addr    in   AW  data address
//  dm_wdata   in   DW  write data
//  dm_gnt     out  1   data request accepted this cycle
//  dm_rvalid  out  1   dm_rdata valid (one cycle after read dm_gnt)
//  dm_rdata   out  DW  load data
//  mem_wen    out  1   to memory wen
//  mem_addr   out  AW  to memory addr
//  mem_din    out  DW  to memory data_in
//  mem_dout   in   DW  from memory data_out (1-cycle read latency)
//  stall_if   out  1   if_req & ~if_gnt
//  stat_if_stall out 16 saturating IF-denied cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Grant is combinational from req and registered state; grants are never both 1.
//  - Priority: DM wins, except when starve_cnt==STARVE_LIMIT and if_req=1, in which case IF wins.
//  - starve_cnt: +1 (saturating at STARVE_LIMIT) each cycle with if_req & ~if_gnt; cleared on if_gnt or ~if_req.
//  - mem_addr/mem_din muxed from the granted requester; idle -> mem_addr=0, mem_din=0.
//  - mem_wen = dm_gnt & dm_we. Writes complete on grant and produce no rvalid.
//  - Read-owner FSM (registered): OWN_NONE, OWN_IF, OWN_DM. Next state = OWN_IF on if_gnt,
//    OWN_DM on dm_gnt & ~dm_we, else OWN_NONE. Back-to-back reads are allowed every cycle.
//  - if_rvalid=(state==OWN_IF); dm_rvalid=(state==OWN_DM); both rdata outputs = mem_dout when valid, else 0.
//  - Latency: read grant at cycle N -> rvalid/rdata at cycle N+1. Write-then-read of the same address in
//    consecutive cycles returns the new data (the memory write at N completes before the read at N+1).
//  - Requester contract: req, addr, we and wdata are held stable until gnt; dropping req before gnt is legal.
//  - While rst=0: if_gnt=dm_gnt=0, mem_wen=0, stall_if=0. At the first edge with rst=0: state=OWN_NONE,
//    starve_cnt=0, all rvalid/rdata=0, stat_if_stall=0.
//  - Reset mid-read: an in-flight read is discarded, so no rvalid appears in the cycle after reset.
//  - DM read and write requests are arbitrated identically; dm_we only changes FSM and mem_wen.
// CONFIGURATION
//  ARB_STATS_EN defined: stat_if_stall increments each cycle stall_if=1 and saturates at 16'hFFFF.
//  ARB_STATS_EN undefined: stat_if_stall is tied to 0 and the counter is not synthesised; the port is always present.
// STRUCTURE
//  - define.v gains owner encodings `OWN_NONE=2'b00, `OWN_IF=2'b01, `OWN_DM=2'b10, plus `STARVE_W=4.
//  - One sub-module: arb_starve_cnt (saturating counter; inputs inc/clr; output at_limit).
//  - Remaining logic (grant mux, owner FSM, return routing) lives flat in mem_port_arbiter.
// TESTING
//  1 IF only: if_req=1, if_addr=0x0005, mem[5]=0x1234 -> if_gnt=1 same cycle; next cycle if_rvalid=1, if_rdata=0x1234.
//  2 Conflict: if_req=1, and dm_req=1 reading 0x0020 (mem=0xA5A5) -> dm_gnt=1, if_gnt=0, stall_if=1;
//    next cycle dm_rvalid=1, dm_rdata=0xA5A5, if_rvalid=0.
//  3 Starvation, STARVE_LIMIT=4: both requesting for 6 cycles -> dm_gnt in cycles 0-3, if_gnt in cycle 4, dm_gnt in cycle 5.
//  4 Write: dm_we=1, dm_addr=0x10, dm_wdata=0xBEEF -> mem_wen=1 that cycle, no dm_rvalid;
//    next-cycle IF read of 0x10 -> if_rdata=0xBEEF.
//  5 Reset mid-read: if_gnt at cycle N, rst=0 at edge N+1 -> if_rvalid=0 at N+1; starve_cnt=0; grants 0 while in reset.
//  6 ARB_STATS_EN: 3 denied IF cycles then release -> stat_if_stall=3; without the macro it stays 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and helpers for the IF/DM memory port arbiter.
package mem_port_arbiter_pkg;
   localparam int STARVE_W = 4;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_IF   = 2'b01;
   localparam logic [1:0] OWN_DM   = 2'b10;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Saturating count of consecutive cycles fetch has been denied; flags when the limit is reached.
module arb_starve_cnt
   import mem_port_arbiter_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);
   logic [STARVE_W-1:0] cnt;

   assign at_limit = (cnt == STARVE_W'(LIMIT));

   always_ff @(posedge clk) begin
      if (!rst)                   cnt <= '0;
      else if (clr)               cnt <= '0;
      else if (inc && !at_limit)  cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data access, tagging reads for return routing.
// Optional ARB_STATS_EN enables the saturating stall_if cycle counter on stat_if_stall.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW           = 16,
   parameter int DW           = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   output logic [DW-1:0] dm_rdata,
   output logic          mem_wen,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout,
   output logic          stall_if,
   output logic [15:0]   stat_if_stall
);
   logic       at_limit;
   logic [1:0] state, state_nxt;

   arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clk      (clk),
      .rst      (rst),
      .inc      (if_req & ~if_gnt),
      .clr      (if_gnt | ~if_req),
      .at_limit (at_limit)
   );

   // DM normally wins; a fetch that has waited STARVE_LIMIT cycles takes the port once.
   assign if_gnt   = rst & if_req & (~dm_req | at_limit);
   assign dm_gnt   = rst & dm_req & ~if_gnt;
   assign stall_if = rst & if_req & ~if_gnt;
   assign mem_wen  = dm_gnt & dm_we;

   always_comb begin
      mem_addr = '0;
      mem_din  = '0;
      if (if_gnt) begin
         mem_addr = if_addr;
      end else if (dm_gnt) begin
         mem_addr = dm_addr;
         mem_din  = dm_wdata;
      end
   end

   always_comb begin
      state_nxt = OWN_NONE;
      if (if_gnt)                state_nxt = OWN_IF;
      else if (dm_gnt && !dm_we) state_nxt = OWN_DM;
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= OWN_NONE;
      else      state <= state_nxt;
   end

   // Gating with rst drops a read still in flight when reset arrives.
   assign if_rvalid = rst & (state == OWN_IF);
   assign dm_rvalid = rst & (state == OWN_DM);
   assign if_rdata  = if_rvalid ? mem_dout : '0;
   assign dm_rdata  = dm_rvalid ? mem_dout : '0;

`ifdef ARB_STATS_EN
   logic [15:0] stat_q;

   always_ff @(posedge clk) begin
      if (!rst)          stat_q <= '0;
      else if (stall_if) stat_q <= sat_inc16(stat_q);
   end

   assign stat_if_stall = stat_q;
`else
   assign stat_if_stall = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a behavioural memory and arbitration model.
module tb_mem_port_arbiter;
   localparam int AW = 16, DW = 16, LIMIT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, dm_req, dm_we;
   logic [AW-1:0] if_addr, dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_wen, stall_if;
   logic [DW-1:0] if_rdata, dm_rdata, mem_din, mem_dout;
   logic [AW-1:0] mem_addr;
   logic [15:0]   stat_if_stall;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
      .stall_if(stall_if), .stat_if_stall(stat_if_stall)
   );

   // Physical single-port memory, one-cycle read latency.
   logic [DW-1:0] mem [0:255];
   always @(posedge clk) begin
      if (mem_wen) mem[mem_addr[7:0]] <= mem_din;
      mem_dout <= mem[mem_addr[7:0]];
   end

   // Reference model state.
   logic [DW-1:0] ref_mem [0:255];
   int            starve = 0;
   logic [15:0]   m_stat = '0;
   logic          m_if, m_dm;

   typedef struct {logic is_if; logic [DW-1:0] data; int due;} exp_t;
   exp_t sb[$];

   int cyc = 0;
   int n_cmp = 0, n_fail = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step(input logic r, input logic ir, input logic [AW-1:0] ia,
                       input logic dr, input logic dw, input logic [AW-1:0] da,
                       input logic [DW-1:0] dd);
      logic          e_stall, e_wen;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_din;
      @(negedge clk);
      rst = r; if_req = ir; if_addr = ia;
      dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
      if (!r) sb.delete();
      #1;
      m_if    = r && ir && (!dr || starve == LIMIT);
      m_dm    = r && dr && !m_if;
      e_stall = r && ir && !m_if;
      e_wen   = m_dm && dw;
      e_addr  = m_if ? ia : (m_dm ? da : '0);
      e_din   = m_dm ? dd : '0;
      n_cmp++;
      if ({if_gnt, dm_gnt, stall_if, mem_wen, mem_addr, mem_din} !==
          {m_if, m_dm, e_stall, e_wen, e_addr, e_din}) begin
         n_fail++;
         $display("FAIL port cyc=%0d got gi=%b gd=%b st=%b we=%b a=%h d=%h exp gi=%b gd=%b st=%b we=%b a=%h d=%h",
                  cyc, if_gnt, dm_gnt, stall_if, mem_wen, mem_addr, mem_din,
                  m_if, m_dm, e_stall, e_wen, e_addr, e_din);
      end
      n_cmp++;
      if (stat_if_stall !== m_stat) begin
         n_fail++;
         $display("FAIL stat cyc=%0d got %h exp %h", cyc, stat_if_stall, m_stat);
      end
      if (m_if)          sb.push_back('{1'b1, ref_mem[ia[7:0]], cyc + 1});
      if (m_dm && !dw)   sb.push_back('{1'b0, ref_mem[da[7:0]], cyc + 1});
      if (e_wen)         ref_mem[da[7:0]] = dd;
      if (!r)            starve = 0;
      else if (e_stall)  starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
      else               starve = 0;
`ifdef ARB_STATS_EN
      if (!r)           m_stat = '0;
      else if (e_stall) m_stat = (m_stat == 16'hFFFF) ? m_stat : m_stat + 16'd1;
`endif
   endtask

   task automatic idle(input logic r);
      step(r, 1'b0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got %h exp %h", name, cyc, got, exp);
      end
   endtask

   // Monitor: compares read returns against the scoreboard every cycle.
   initial begin
      exp_t          ent;
      logic          e_iv, e_dv;
      logic [DW-1:0] e_id, e_dd;
      forever begin
         @(negedge clk);
         #2;
         e_iv = 1'b0; e_dv = 1'b0; e_id = '0; e_dd = '0;
         if (sb.size() > 0 && sb[0].due == cyc) begin
            ent = sb.pop_front();
            if (ent.is_if) begin e_iv = 1'b1; e_id = ent.data; end
            else           begin e_dv = 1'b1; e_dd = ent.data; end
         end
         n_cmp++;
         if ({if_rvalid, dm_rvalid, if_rdata, dm_rdata} !== {e_iv, e_dv, e_id, e_dd}) begin
            n_fail++;
            $display("FAIL rdata cyc=%0d got iv=%b dv=%b id=%h dd=%h exp iv=%b dv=%b id=%h dd=%h",
                     cyc, if_rvalid, dm_rvalid, if_rdata, dm_rdata, e_iv, e_dv, e_id, e_dd);
         end
      end
   end

   initial begin
      logic [5:0]    seq;
      logic          if_p, dm_p, dm_w, r;
      logic [AW-1:0] if_a, dm_a;
      logic [DW-1:0] dm_d;
      rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = DW'($urandom);
         mem[i]     = ref_mem[i];
      end
      ref_mem[8'h05] = 16'h1234; mem[8'h05] = 16'h1234;
      ref_mem[8'h20] = 16'hA5A5; mem[8'h20] = 16'hA5A5;

      // Reset with both requesting: no grants, no stall.
      step(1'b0, 1'b1, 16'h3, 1'b1, 1'b1, 16'h4, 16'h55);
      step(1'b0, 1'b1, 16'h3, 1'b1, 1'b0, 16'h4, 16'h0);
      idle(1'b1);

      // IF only.
      step(1'b1, 1'b1, 16'h0005, 1'b0, 1'b0, '0, '0);
      idle(1'b1);
      check("if_only", {15'd0, if_rvalid, if_rdata}, {15'd0, 1'b1, 16'h1234});

      // Conflict: DM wins.
      step(1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 16'h0020, '0);
      idle(1'b1);
      check("conflict", {14'd0, dm_rvalid, if_rvalid, dm_rdata}, {14'd0, 2'b10, 16'hA5A5});

      // Starvation: IF wins on the fifth cycle of conflict.
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 1'b1, 16'h0006, 1'b1, 1'b0, 16'h0021, '0);
         seq[k] = if_gnt;
      end
      check("starve_seq", {26'd0, seq}, {26'd0, 6'b010000});
      idle(1'b1);

      // Write then read-after-write through the other port.
      step(1'b1, 1'b0, '0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
      step(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, '0, '0);
      idle(1'b1);
      check("raw", {15'd0, if_rvalid, if_rdata}, {15'd0, 1'b1, 16'hBEEF});

      // Reset mid-read discards the return.
      step(1'b1, 1'b1, 16'h0005, 1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 16'h7, '0);
      check("rst_midread", {31'd0, if_rvalid}, 32'd0);
      idle(1'b0);
      idle(1'b1);

      // Stall statistic: three denied fetch cycles.
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 16'h0008, 1'b1, 1'b0, 16'h0009, '0);
      idle(1'b1);
`ifdef ARB_STATS_EN
      check("stat3", {16'd0, stat_if_stall}, 32'd3);
`else
      check("stat3", {16'd0, stat_if_stall}, 32'd0);
`endif
      idle(1'b1);

      // Randomized traffic honouring the hold-until-grant contract.
      if_p = 1'b0; dm_p = 1'b0; dm_w = 1'b0;
      if_a = '0; dm_a = '0; dm_d = '0;
      for (int n = 0; n < 3000; n++) begin
         if (!if_p && ($urandom % 3 != 0)) begin
            if_p = 1'b1; if_a = AW'($urandom_range(0, 31));
         end else if (if_p && ($urandom % 25 == 0)) begin
            if_p = 1'b0;
         end
         if (!dm_p && ($urandom % 4 != 0)) begin
            dm_p = 1'b1; dm_w = ($urandom % 3 == 0);
            dm_a = AW'($urandom_range(0, 31)); dm_d = DW'($urandom);
         end else if (dm_p && ($urandom % 25 == 0)) begin
            dm_p = 1'b0;
         end
         r = ($urandom % 250 != 0);
         step(r, if_p, if_a, dm_p, dm_w, dm_a, dm_d);
         if (m_if) if_p = 1'b0;
         if (m_dm) dm_p = 1'b0;
      end

      idle(1'b1);
      idle(1'b1);
      check("sb_drained", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
